scan_ctrl: RTL

Scan-test sequencer that drives one scan chain from the tester side: it accepts parallel test patterns, serialises them onto `scan_in` under `scan_en`, issues one functional capture cycle, and deserialises `scan_out` back into parallel responses. It sits beside a scan-inserted core such as a `scanff` chain and shares that core's `CK`. Unload of pattern N overlaps load of pattern N+1 whenever N+1 is already offered.

---
 rtl/scan_pkg.sv | 9 +
 rtl/scan_shreg.sv | 18 +
 rtl/scan_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state type and default chain length for the scan sequencer
package scan_pkg;
    localparam int SCAN_CHAIN_LEN = 7;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } scan_state_t;
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: parallel-load / serial-in shift register, used as PISO for load and SIPO for unload
module scan_shreg #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    input  logic         sin,
    output logic [W-1:0] q
);
    // load wins over shift; data moves towards the MSB, new bit enters at bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else q <= load ? d : shift ? {q[W-2:0], sin} : q;
    end
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: tester-side scan sequencer that loads, captures and unloads one scan chain
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic                 scan_out,
    output logic                 scan_in,
    output logic                 scan_en,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy,
    output logic                 overflow
);
    scan_state_t          state, nxt_state;
    logic [CNT_W-1:0]     cnt;
    logic                 unload, flush, shifting, last, deliver, ld_load;
    logic [CHAIN_LEN-1:0] ld_q, rs_q;
    logic                 unused_bits;
    assign shifting    = state == SHIFT;
    assign last        = shifting && cnt == CNT_W'(CHAIN_LEN - 1);
    assign deliver     = last && unload;
    assign pat_ready   = !shifting;
    assign busy        = state != IDLE;
    assign ld_load     = (state == IDLE && pat_valid) || state == CAPTURE;
    // the load register has shifted itself empty by CAPTURE/IDLE, so its MSB is a clean registered scan_in
    assign scan_in     = ld_q[CHAIN_LEN-1];
    assign unused_bits = ^{ld_q[CHAIN_LEN-2:0], rs_q[CHAIN_LEN-1]};
    scan_shreg #(.W(CHAIN_LEN)) u_load (
        .clk   (CK),
        .rst_n (RN),
        .load  (ld_load),
        .shift (shifting),
        .d     (pat_valid ? pat_data : '0),
        .sin   (1'b0),
        .q     (ld_q)
    );
    scan_shreg #(.W(CHAIN_LEN)) u_unload (
        .clk   (CK),
        .rst_n (RN),
        .load  (1'b0),
        .shift (shifting && unload),
        .d     ('0),
        .sin   (scan_out),
        .q     (rs_q)
    );
    // next state: a flush pass ends in IDLE, any other pass ends in CAPTURE
    always_comb begin
        nxt_state = state == IDLE    ? (pat_valid ? SHIFT : IDLE) :
                    state == CAPTURE ? SHIFT :
                    last             ? (flush ? IDLE : CAPTURE) : state;
    end
    // FSM, bit counter, pass flags and the registered scan_en
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            cnt     <= '0;
            unload  <= 1'b0;
            flush   <= 1'b0;
            scan_en <= 1'b0;
        end else begin
            state   <= nxt_state;
            scan_en <= nxt_state == SHIFT;
            cnt     <= shifting && !last ? cnt + CNT_W'(1) : '0;
            if (state == IDLE && pat_valid) begin
                unload <= 1'b0;
                flush  <= 1'b0;
            end
            if (state == CAPTURE) begin
                unload <= 1'b1;
                flush  <= !pat_valid;
            end
        end
    end
    // response hand-off: the last unload edge writes the word; overwriting an unconsumed word is sticky overflow
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            resp_data  <= '0;
            resp_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (deliver) resp_data <= {rs_q[CHAIN_LEN-2:0], scan_out};
            resp_valid <= deliver || (resp_valid && !resp_ready);
            if (deliver && resp_valid && !resp_ready) overflow <= 1'b1;
        end
    end
endmodule
